// File: rtl/div_ctrl_pkg.sv
// Shared constants for the HI/LO divide sequencer: state encodings, handshake levels, bus widths.
// Optional signed support is selected with DIV_SIGNED_EN (see div_ctrl.sv).
package div_ctrl_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    // Two's-complement negate when c is set; wraps modulo 2^32 (so -0x80000000 stays 0x80000000).
    function automatic logic [RegBus-1:0] neg_if(input logic c, input logic [RegBus-1:0] v);
        return c ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// EX <-> divider handshake: operands and request in, HI/LO result, ready and stall out.
interface div_ctrl_if;
    import div_ctrl_pkg::*;

    logic                    start_i;
    logic                    annul_i;
    logic                    signed_i;
    logic [RegBus-1:0]       opdata1_i;
    logic [RegBus-1:0]       opdata2_i;
    logic [DoubleRegBus-1:0] result_o;
    logic                    ready_o;
    logic                    stall_req_o;

    modport master (
        output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stall_req_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stall_req_o
    );

endinterface

// File: rtl/div_ctrl_step.sv
// One restoring-division step: trial-subtract the divisor from the partial remainder,
// keep the difference and shift in a 1 if it fits, otherwise shift in a 0.
module div_step
    import div_ctrl_pkg::*;
(
    input  logic [DoubleRegBus:0] work,
    input  logic [RegBus-1:0]     divisor,
    output logic [DoubleRegBus:0] work_nxt
);

    logic [RegBus:0] minuend;

    assign minuend = work[DoubleRegBus:RegBus] - {1'b0, divisor};

    // minuend[32] is the borrow: divisor did not fit into the partial remainder.
    always_comb begin
        work_nxt = {work[DoubleRegBus-1:0], 1'b0};
        if (!minuend[RegBus])
            work_nxt = {minuend[RegBus-1:0], work[RegBus-1:0], 1'b1};
    end

endmodule

// File: rtl/div_ctrl.sv
// 32-step restoring divider for DIV/DIVU; returns {HI=remainder, LO=quotient}.
// Define DIV_SIGNED_EN to honour signed_i (operand magnitudes and result sign fix).
module div_ctrl
    import div_ctrl_pkg::*;
(
    input logic      clk,
    input logic      rst,
    div_ctrl_if.slave bus
);

    logic [1:0]              state;
    logic [5:0]              cnt;
    logic [DoubleRegBus:0]   work;
    logic [DoubleRegBus:0]   work_nxt;
    logic [RegBus-1:0]       divisor;
    logic [RegBus-1:0]       op1_mag;
    logic [RegBus-1:0]       op2_mag;
    logic [RegBus-1:0]       quo_fix;
    logic [RegBus-1:0]       rem_fix;
    logic [DoubleRegBus-1:0] result_q;
    logic                    ready_q;

    div_step u_step (
        .work     (work),
        .divisor  (divisor),
        .work_nxt (work_nxt)
    );

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic neg_q_nxt;
    logic neg_r_nxt;

    assign op1_mag   = neg_if(bus.signed_i & bus.opdata1_i[RegBus-1], bus.opdata1_i);
    assign op2_mag   = neg_if(bus.signed_i & bus.opdata2_i[RegBus-1], bus.opdata2_i);
    assign neg_q_nxt = bus.signed_i & (bus.opdata1_i[RegBus-1] ^ bus.opdata2_i[RegBus-1]);
    assign neg_r_nxt = bus.signed_i & bus.opdata1_i[RegBus-1];
    // Remainder follows the dividend's sign, quotient is negative when the signs differ.
    assign quo_fix   = neg_if(neg_q, work[RegBus-1:0]);
    assign rem_fix   = neg_if(neg_r, work[DoubleRegBus:RegBus+1]);
`else
    assign op1_mag = bus.opdata1_i;
    assign op2_mag = bus.opdata2_i;
    assign quo_fix = work[RegBus-1:0];
    assign rem_fix = work[DoubleRegBus:RegBus+1];
`endif

    assign bus.result_o    = result_q;
    assign bus.ready_o     = ready_q;
    assign bus.stall_req_o = bus.start_i & ~ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            divisor  <= ZeroWord;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            case (state)
                DivFree: begin
                    result_q <= '0;
                    ready_q  <= DivResultNotReady;
                    if (bus.start_i == DivStart && !bus.annul_i) begin
                        if (bus.opdata2_i == ZeroWord) begin
                            state <= DivByZero;
                        end else begin
                            state   <= DivOn;
                            cnt     <= '0;
                            divisor <= op2_mag;
                            work    <= {ZeroWord, op1_mag, 1'b0};
`ifdef DIV_SIGNED_EN
                            neg_q   <= neg_q_nxt;
                            neg_r   <= neg_r_nxt;
`endif
                        end
                    end
                end
                DivByZero: begin
                    if (bus.annul_i) begin
                        state <= DivFree;
                    end else begin
                        state    <= DivEnd;
                        result_q <= '0;
                        ready_q  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (bus.annul_i) begin
                        state <= DivFree;
                    end else if (cnt != 6'd32) begin
                        work <= work_nxt;
                        cnt  <= cnt + 6'd1;
                    end else begin
                        state    <= DivEnd;
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    // Result is held until EX drops start_i, so a back-to-back request is not taken here.
                    if (bus.annul_i || bus.start_i == DivStop) begin
                        state    <= DivFree;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule
